// File: rtl/fetch_aligner.sv
// Instruction-fetch realignment stage: turns word-aligned 32-bit fetch words
// into one whole RVC/standard instruction per cycle, carrying a leftover
// halfword between fetches so 32-bit instructions may straddle two words.
module fetch_aligner #(
    parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_read,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        inst_valid,
    output logic [31:0] inst_raw,
    output logic        is_c,
    output logic [31:0] inst_pc
);

    // EMPTY: no buffered halfword. HALF: r_lo_buf holds the halfword at r_pc
    // (so r_pc[1] is always 1 in HALF).
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    state_t      r_st;
    state_t      w_st_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [15:0] r_lo_buf;
    logic [15:0] w_lo_buf_next;
    logic        r_inst_valid;
    logic        w_inst_valid_next;
    logic [31:0] r_inst_raw;
    logic [31:0] w_inst_raw_next;
    logic        r_is_c;
    logic        w_is_c_next;
    logic [31:0] r_inst_pc;
    logic [31:0] w_inst_pc_next;

    logic        w_lo_is_c;
    logic        w_need_fetch;
    logic        w_accept;
    logic [31:0] w_pc_plus2;
    logic [31:0] w_pc_plus4;

    // A compressed halfword in the buffer can be issued without touching memory.
    assign w_lo_is_c    = (r_lo_buf[1:0] != 2'b11);
    assign w_need_fetch = !((r_st == ST_HALF) && w_lo_is_c);
    assign w_accept     = mem_read && !mem_stall;
    assign w_pc_plus2   = r_pc + 32'd2;
    assign w_pc_plus4   = r_pc + 32'd4;

    // Fetch request: in HALF the buffered halfword already covers the current
    // word, so the next word is the one needed.
    always_comb begin
        mem_read = !id_stall && w_need_fetch;
        mem_addr = (r_st == ST_HALF) ? (r_pc[31:2] + 30'd1) : r_pc[31:2];
    end

    // Next-state and next-output decode; redirect beats id_stall beats normal flow.
    always_comb begin
        w_st_next         = r_st;
        w_pc_next         = r_pc;
        w_lo_buf_next     = r_lo_buf;
        w_inst_valid_next = r_inst_valid;
        w_inst_raw_next   = r_inst_raw;
        w_is_c_next       = r_is_c;
        w_inst_pc_next    = r_inst_pc;

        if (redirect) begin
            w_pc_next         = {redirect_pc[31:1], 1'b0};
            w_st_next         = ST_EMPTY;
            w_inst_valid_next = 1'b0;
        end else if (id_stall) begin
            // hold everything
        end else begin
            w_inst_valid_next = 1'b0;
            case (r_st)
                ST_EMPTY: begin
                    if (w_accept) begin
                        if (r_pc[1]) begin
                            // Halfword-aligned target: only the upper half is
                            // useful; buffer it and take a one-cycle bubble.
                            w_lo_buf_next = mem_rdata[31:16];
                            w_st_next     = ST_HALF;
                        end else if (mem_rdata[1:0] != 2'b11) begin
                            w_inst_valid_next = 1'b1;
                            w_inst_raw_next   = {16'b0, mem_rdata[15:0]};
                            w_is_c_next       = 1'b1;
                            w_inst_pc_next    = r_pc;
                            w_lo_buf_next     = mem_rdata[31:16];
                            w_pc_next         = w_pc_plus2;
                            w_st_next         = ST_HALF;
                        end else begin
                            w_inst_valid_next = 1'b1;
                            w_inst_raw_next   = mem_rdata;
                            w_is_c_next       = 1'b0;
                            w_inst_pc_next    = r_pc;
                            w_pc_next         = w_pc_plus4;
                        end
                    end
                end
                ST_HALF: begin
                    if (w_lo_is_c) begin
                        w_inst_valid_next = 1'b1;
                        w_inst_raw_next   = {16'b0, r_lo_buf};
                        w_is_c_next       = 1'b1;
                        w_inst_pc_next    = r_pc;
                        w_pc_next         = w_pc_plus2;
                        w_st_next         = ST_EMPTY;
                    end else if (w_accept) begin
                        // Straddling 32-bit instruction: low half buffered,
                        // high half from the new word.
                        w_inst_valid_next = 1'b1;
                        w_inst_raw_next   = {mem_rdata[15:0], r_lo_buf};
                        w_is_c_next       = 1'b0;
                        w_inst_pc_next    = r_pc;
                        w_lo_buf_next     = mem_rdata[31:16];
                        w_pc_next         = w_pc_plus4;
                    end
                end
                default: begin
                    w_st_next = ST_EMPTY;
                end
            endcase
        end
    end

    // State and output registers with immediate reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st         <= ST_EMPTY;
            r_pc         <= {BOOT_PC[31:1], 1'b0};
            r_lo_buf     <= 16'h0000;
            r_inst_valid <= 1'b0;
            r_inst_raw   <= 32'h0000_0000;
            r_is_c       <= 1'b0;
            r_inst_pc    <= 32'h0000_0000;
        end else begin
            r_st         <= w_st_next;
            r_pc         <= w_pc_next;
            r_lo_buf     <= w_lo_buf_next;
            r_inst_valid <= w_inst_valid_next;
            r_inst_raw   <= w_inst_raw_next;
            r_is_c       <= w_is_c_next;
            r_inst_pc    <= w_inst_pc_next;
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst_raw   = r_inst_raw;
    assign is_c       = r_is_c;
    assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: a small word memory answers fetches
// combinationally; expected values are hand-computed per scenario.
module tb_fetch_aligner;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        inst_valid;
    logic [31:0] inst_raw;
    logic        is_c;
    logic [31:0] inst_pc;

    logic [31:0] mem [0:255];
    int          n_vec;
    int          n_err;

    fetch_aligner #(.BOOT_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_stall  (mem_stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_stall   (id_stall),
        .inst_valid (inst_valid),
        .inst_raw   (inst_raw),
        .is_c       (is_c),
        .inst_pc    (inst_pc)
    );

    assign mem_rdata = mem[mem_addr[7:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] raw,
                            input logic c, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, inst_valid}, 32'd1);
        chk({tag, ".raw"},   inst_raw, raw);
        chk({tag, ".is_c"},  {31'b0, is_c}, {31'b0, c});
        chk({tag, ".pc"},    inst_pc, pc);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        mem_stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        id_stall = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // 1: reset state and a single 32-bit instruction
        #1;
        @(posedge clk);
        #1;
        chk("rst.valid", {31'b0, inst_valid}, 32'd0);
        chk("rst.raw", inst_raw, 32'd0);
        chk("rst.is_c", {31'b0, is_c}, 32'd0);
        chk("rst.pc", inst_pc, 32'd0);
        mem[0] = 32'h0000_0013;
        rst = 1'b0;
        #1;
        chk("t1.mem_read", {31'b0, mem_read}, 32'd1);
        chk("t1.mem_addr", {2'b0, mem_addr}, 32'd0);
        tick();
        chk_inst("t1.i0", 32'h0000_0013, 1'b0, 32'h0);
        chk("t1.next_addr", {2'b0, mem_addr}, 32'd1);

        // 2: two compressed instructions in one word
        mem[0] = 32'h4501_4501;
        do_reset();
        tick();
        chk_inst("t2.i0", 32'h0000_4501, 1'b1, 32'h0);
        chk("t2.no_read", {31'b0, mem_read}, 32'd0);
        tick();
        chk_inst("t2.i1", 32'h0000_4501, 1'b1, 32'h2);
        chk("t2.addr", {2'b0, mem_addr}, 32'd1);

        // 3: straddling 32-bit instruction
        mem[0] = 32'h0013_4501;
        mem[1] = 32'h4501_0000;
        do_reset();
        tick();
        chk_inst("t3.i0", 32'h0000_4501, 1'b1, 32'h0);
        chk("t3.addr", {2'b0, mem_addr}, 32'd1);
        chk("t3.read", {31'b0, mem_read}, 32'd1);
        tick();
        chk_inst("t3.i1", 32'h0000_0013, 1'b0, 32'h2);
        tick();
        chk_inst("t3.i2", 32'h0000_4501, 1'b1, 32'h6);

        // 4: redirect to odd-halfword target during a memory stall
        mem[8'h40] = 32'h6785_0013;
        mem[8'h41] = 32'h0000_0073;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        mem_stall = 1'b1;
        tick();
        redirect = 1'b0;
        mem_stall = 1'b0;
        #1;
        chk("t4.valid", {31'b0, inst_valid}, 32'd0);
        chk("t4.addr", {2'b0, mem_addr}, 32'h40);
        tick();
        chk("t4.bubble", {31'b0, inst_valid}, 32'd0);
        tick();
        chk_inst("t4.i0", 32'h0000_6785, 1'b1, 32'h102);
        chk("t4.addr2", {2'b0, mem_addr}, 32'h41);
        mem_stall = 1'b1;
        tick();
        chk("t4.stall", {31'b0, inst_valid}, 32'd0);
        chk("t4.stall_addr", {2'b0, mem_addr}, 32'h41);
        mem_stall = 1'b0;
        tick();
        chk_inst("t4.i1", 32'h0000_0073, 1'b0, 32'h104);

        // 5: id_stall held 3 cycles in HALF
        mem[0] = 32'h0013_4501;
        mem[1] = 32'h4501_0000;
        do_reset();
        tick();
        id_stall = 1'b1;
        #1;
        chk("t5.no_read", {31'b0, mem_read}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_inst($sformatf("t5.hold%0d", k), 32'h0000_4501, 1'b1, 32'h0);
        end
        id_stall = 1'b0;
        #1;
        chk("t5.resume_addr", {2'b0, mem_addr}, 32'd1);
        tick();
        chk_inst("t5.i1", 32'h0000_0013, 1'b0, 32'h2);
        tick();
        chk_inst("t5.i2", 32'h0000_4501, 1'b1, 32'h6);

        // redirect wins over id_stall
        id_stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        id_stall = 1'b0;
        redirect = 1'b0;
        #1;
        chk("t5.redir_valid", {31'b0, inst_valid}, 32'd0);

        // wrap-around: straddle from the last halfword of memory into word 0
        mem[8'hFF] = 32'h0013_0000;
        mem[0] = 32'h0000_0000;
        chk("wr.addr", {2'b0, mem_addr}, 32'h3FFF_FFFF);
        tick();
        chk("wr.bubble", {31'b0, inst_valid}, 32'd0);
        chk("wr.addr_wrap", {2'b0, mem_addr}, 32'd0);
        tick();
        chk_inst("wr.i0", 32'h0000_0013, 1'b0, 32'hFFFF_FFFE);
        tick();
        chk_inst("wr.i1", 32'h0000_0000, 1'b1, 32'h2);

        // 6: asynchronous reset mid-cycle while in HALF
        mem[0] = 32'h4501_4501;
        do_reset();
        tick();
        chk_inst("t6.pre", 32'h0000_4501, 1'b1, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6.valid", {31'b0, inst_valid}, 32'd0);
        chk("t6.raw", inst_raw, 32'd0);
        chk("t6.pc", inst_pc, 32'd0);
        chk("t6.is_c", {31'b0, is_c}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6.read", {31'b0, mem_read}, 32'd1);
        chk("t6.addr", {2'b0, mem_addr}, 32'd0);
        tick();
        chk_inst("t6.i0", 32'h0000_4501, 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction-fetch realignment stage, sitting between instruction memory/I-cache and the RVC decompressor.
- Consumes word-aligned 32-bit fetch words. Emits one whole instruction per cycle with its PC: 16-bit compressed, or 32-bit standard, including 32-bit instructions that straddle two words.
- Holds one 16-bit leftover halfword between fetches. Handles halfword-aligned redirect targets.

Parameters:
- BOOT_PC, 32'h0000_0000, PC loaded on reset (bit 0 must be 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  out  1  fetch request, combinational.
- mem_addr  out  30  word address of the requested word, combinational.
- mem_rdata  in  32  fetched word, valid in the same cycle when mem_read=1 and mem_stall=0.
- mem_stall  in  1  memory not ready; word not accepted this cycle.
- redirect  in  1  branch/jump taken; flush and restart at redirect_pc.
- redirect_pc  in  32  new PC; bit 0 ignored.
- id_stall  in  1  downstream hold.
- inst_valid  out  1  registered; inst_raw/inst_pc/is_c are meaningful.
- inst_raw  out  32  registered; {16'b0, half} when is_c=1, otherwise the full 32-bit instruction.
- is_c  out  1  registered; instruction is compressed (raw[1:0] != 2'b11).
- inst_pc  out  32  registered; PC of the emitted instruction.

Behaviour:
Internal state:
- pc: PC of the next instruction to emit, halfword-aligned.
- lo_buf[15:0]: leftover halfword.
- st: EMPTY or HALF.
- In HALF, pc[1]=1 always and lo_buf holds the halfword at pc.

Reset (async, immediate):
- pc=BOOT_PC, st=EMPTY.
- inst_valid=0, inst_raw=0, is_c=0, inst_pc=0.

mem_read / mem_addr:
- mem_addr = pc[31:2] in EMPTY; pc[31:2]+1 in HALF.
- mem_read = !id_stall && !(st==HALF && lo_buf[1:0]!=2'b11).

Priority per rising edge: redirect > id_stall > normal.
- redirect:
  - pc=redirect_pc & ~1, st=EMPTY, inst_valid=0.
  - Any word returned that cycle is discarded.
  - Wins over id_stall.
- id_stall (no redirect): all state and outputs hold.
- Normal operation, "word accepted" = mem_read && !mem_stall. W = mem_rdata.
- EMPTY, pc[1]=0, accepted:
  - If W[1:0]!=11: emit {16'b0, W[15:0]}, is_c=1, inst_pc=pc; lo_buf=W[31:16]; pc+=2; st=HALF.
  - Else: emit W, is_c=0, inst_pc=pc; pc+=4; st stays EMPTY.
- EMPTY, pc[1]=1, accepted:
  - lo_buf=W[31:16], st=HALF, pc unchanged.
  - inst_valid=0 (one bubble after a halfword-aligned redirect).
- HALF, lo_buf[1:0]!=11 (no fetch):
  - Emit {16'b0, lo_buf}, is_c=1, inst_pc=pc; pc+=2; st=EMPTY.
- HALF, lo_buf[1:0]==11, accepted:
  - Emit {W[15:0], lo_buf}, is_c=0, inst_pc=pc.
  - lo_buf=W[31:16]; pc+=4; st stays HALF.
- Any state where a fetch is needed but not accepted (mem_stall=1):
  - inst_valid=0; pc, st and lo_buf hold.
- Wrap-around: pc arithmetic is modulo 2^32; mem_addr+1 wraps modulo 2^30.
- Throughput: one instruction per cycle except the post-redirect bubble and memory stalls.
- Latency: the word is accepted in cycle N; the instruction appears on the outputs after edge N.

Test Plan:
1. Reset with BOOT_PC=0; word0=32'h0000_0013 -> inst_raw=32'h0000_0013, is_c=0, inst_pc=0; next mem_addr=1.
2. word0=32'h4501_4501 -> cycle1: raw=16'h4501, is_c=1, pc=0. Cycle2: mem_read=0; raw=16'h4501, pc=2. Then mem_addr=1.
3. Straddle: word0=32'h0013_4501, word1=32'h4501_0000 -> emits, in order:
   - c 0x4501 @pc 0;
   - 32'h0000_0013 @pc 2, with mem_addr=1 that cycle;
   - c 0x4501 @pc 6.
4. redirect=1, redirect_pc=32'h103, in the same cycle as mem_stall=1 -> next: inst_valid=0, pc=0x102. Then mem_addr=0x40; one bubble; then the upper half of word 0x40 @pc 0x102.
5. id_stall held 3 cycles in HALF -> mem_read=0; outputs, pc and lo_buf unchanged; resumes with no lost or duplicated instruction.
6. rst asserted mid-cycle while in HALF -> outputs go to 0 immediately; after release, fetch restarts at mem_addr=BOOT_PC[31:2].
